// File: rtl/stream_join_pkg.sv
`default_nettype none
// ============================================================================
// stream_join_pkg : shared types for the runtime-configurable stream join
// Revision: 1.0
// ============================================================================
package stream_join_pkg;

    typedef enum logic [0:0] {
        STREAM_JOIN_ALL = 1'b0,
        STREAM_JOIN_ANY = 1'b1
    } stream_join_mode_e;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } stream_join_sched_state_e;

endpackage
`default_nettype wire

// File: rtl/stream_join_dynamic.sv
`default_nettype none
// ============================================================================
// stream_join_dynamic : combinational join of selected streams, ALL or ANY mode
// Revision: 1.0
// ============================================================================
module stream_join_dynamic
    import stream_join_pkg::*;
#(
    parameter int unsigned NumInp = 4
) (
    input  logic [NumInp-1:0] sel_i,
    input  stream_join_mode_e mode_i,
    input  logic [NumInp-1:0] inp_valid_i,
    output logic [NumInp-1:0] inp_ready_o,
    output logic              oup_valid_o,
    input  logic              oup_ready_i,
    output logic [NumInp-1:0] oup_sel_o
);

    always_comb begin
        oup_valid_o = 1'b0;
        inp_ready_o = '0;
        oup_sel_o   = '0;
        if (mode_i == STREAM_JOIN_ALL) begin
            // Unselected inputs count as always valid so they never block the join.
            oup_valid_o = &(inp_valid_i | ~sel_i);
            inp_ready_o = sel_i & {NumInp{oup_valid_o & oup_ready_i}};
            oup_sel_o   = sel_i;
        end else begin
            oup_valid_o = |(inp_valid_i & sel_i);
            inp_ready_o = sel_i & inp_valid_i & {NumInp{oup_ready_i}};
            oup_sel_o   = inp_valid_i & sel_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_join_sched.sv
`default_nettype none
// ============================================================================
// stream_join_sched : job-based scheduler running a fixed-length stream join
// Revision: 1.0
// ============================================================================
module stream_join_sched
    import stream_join_pkg::*;
#(
    parameter int unsigned NumInp   = 4,
    parameter int unsigned CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [NumInp-1:0]   cfg_sel_i,
    input  stream_join_mode_e   cfg_mode_i,
    input  logic [CntWidth-1:0] cfg_beats_i,
    input  logic [NumInp-1:0]   inp_valid_i,
    output logic [NumInp-1:0]   inp_ready_o,
    output logic                oup_valid_o,
    input  logic                oup_ready_i,
    output logic [NumInp-1:0]   oup_sel_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [CntWidth-1:0] beat_cnt_o
);

    stream_join_sched_state_e state_q, state_d;
    logic [NumInp-1:0]   sel_q;
    stream_join_mode_e   mode_q;
    logic [CntWidth-1:0] remaining_q;
    logic [CntWidth-1:0] beat_cnt_q;
    logic                done_q;

    logic                active;
    logic                cfg_hs;
    logic                cfg_empty;
    logic                xfer;
    logic                last_beat;
    logic                join_valid;
    logic [NumInp-1:0]   join_ready;
    logic [NumInp-1:0]   join_sel;

    assign active    = (state_q == ACTIVE);
    assign cfg_hs    = cfg_valid_i & cfg_ready_o;
    assign cfg_empty = (cfg_beats_i == '0) || (cfg_sel_i == '0);
    assign xfer      = oup_valid_o & oup_ready_i;
    assign last_beat = (remaining_q == CntWidth'(1));

    // Only registered config feeds the join, keeping cfg_* off the data path.
    stream_join_dynamic #(
        .NumInp (NumInp)
    ) u_join (
        .sel_i       (sel_q),
        .mode_i      (mode_q),
        .inp_valid_i (inp_valid_i),
        .inp_ready_o (join_ready),
        .oup_valid_o (join_valid),
        .oup_ready_i (oup_ready_i),
        .oup_sel_o   (join_sel)
    );

    assign cfg_ready_o = ~active;
    assign busy_o      = active;
    assign oup_valid_o = active & join_valid;
    assign inp_ready_o = join_ready & {NumInp{active}};
    assign oup_sel_o   = join_sel & {NumInp{active}};
    assign done_o      = done_q;
    assign beat_cnt_o  = beat_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_hs && !cfg_empty) state_d = ACTIVE;
            ACTIVE:  if (xfer && last_beat)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel_q       <= '0;
            mode_q      <= STREAM_JOIN_ALL;
            remaining_q <= '0;
            beat_cnt_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (cfg_hs) begin
                sel_q       <= cfg_sel_i;
                mode_q      <= cfg_mode_i;
                remaining_q <= cfg_beats_i;
                beat_cnt_q  <= '0;
                // Empty jobs complete immediately without entering ACTIVE.
                done_q      <= cfg_empty;
            end else if (xfer) begin
                remaining_q <= remaining_q - CntWidth'(1);
                beat_cnt_q  <= beat_cnt_q + CntWidth'(1);
                done_q      <= last_beat;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_join_sched.sv
`default_nettype none
// ============================================================================
// tb_stream_join_sched : directed bench with a job-level reference model
// Revision: 1.0
// ============================================================================
module tb_stream_join_sched;
    import stream_join_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [3:0]        cfg_sel;
    stream_join_mode_e cfg_mode;
    logic [15:0]       cfg_beats;
    logic [3:0]        inp_valid;
    logic [3:0]        inp_ready;
    logic              oup_valid;
    logic              oup_ready;
    logic [3:0]        oup_sel;
    logic              busy;
    logic              done;
    logic [15:0]       beat_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    stream_join_sched #(.NumInp(4), .CntWidth(16)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready),
        .cfg_sel_i   (cfg_sel),
        .cfg_mode_i  (cfg_mode),
        .cfg_beats_i (cfg_beats),
        .inp_valid_i (inp_valid),
        .inp_ready_o (inp_ready),
        .oup_valid_o (oup_valid),
        .oup_ready_i (oup_ready),
        .oup_sel_o   (oup_sel),
        .busy_o      (busy),
        .done_o      (done),
        .beat_cnt_o  (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- job-level reference model ----------------
    logic              m_active;
    logic              m_done;
    logic [3:0]        m_sel;
    stream_join_mode_e m_mode;
    int                m_left;
    int                m_cnt;

    function automatic logic exp_valid();
        logic v;
        if (!m_active) return 1'b0;
        if (m_mode == STREAM_JOIN_ALL) begin
            v = 1'b1;
            for (int i = 0; i < 4; i++) if (m_sel[i] && !inp_valid[i]) v = 1'b0;
        end else begin
            v = 1'b0;
            for (int i = 0; i < 4; i++) if (m_sel[i] && inp_valid[i]) v = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [3:0] exp_ready();
        logic [3:0] r;
        r = 4'b0;
        for (int i = 0; i < 4; i++) begin
            if (m_active && m_sel[i] && oup_ready) begin
                if (m_mode == STREAM_JOIN_ALL) r[i] = exp_valid();
                else                           r[i] = inp_valid[i];
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] exp_sel();
        if (!m_active) return 4'b0;
        return (m_mode == STREAM_JOIN_ALL) ? m_sel : (m_sel & inp_valid);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_sel    <= 4'b0;
            m_mode   <= STREAM_JOIN_ALL;
            m_left   <= 0;
            m_cnt    <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_active) begin
                if (cfg_valid) begin
                    m_sel  <= cfg_sel;
                    m_mode <= cfg_mode;
                    m_left <= int'(cfg_beats);
                    m_cnt  <= 0;
                    if (cfg_beats == 16'd0 || cfg_sel == 4'b0) m_done <= 1'b1;
                    else                                        m_active <= 1'b1;
                end
            end else if (exp_valid() && oup_ready) begin
                m_left <= m_left - 1;
                m_cnt  <= m_cnt + 1;
                if (m_left == 1) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("cfg_ready", {31'b0, cfg_ready}, {31'b0, !m_active});
        check("busy",      {31'b0, busy},      {31'b0, m_active});
        check("state",     {31'b0, dut.state_q == ACTIVE}, {31'b0, m_active});
        check("done",      {31'b0, done},      {31'b0, m_done});
        check("beat_cnt",  {16'b0, beat_cnt},  m_cnt);
        check("oup_valid", {31'b0, oup_valid}, {31'b0, exp_valid()});
        check("inp_ready", {28'b0, inp_ready}, {28'b0, exp_ready()});
        check("oup_sel",   {28'b0, oup_sel},   {28'b0, exp_sel()});
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [3:0] sel, input stream_join_mode_e mode, input logic [15:0] beats);
        cfg_valid = 1'b1;
        cfg_sel   = sel;
        cfg_mode  = mode;
        cfg_beats = beats;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_sel   = 4'b0;
        cfg_mode  = STREAM_JOIN_ALL;
        cfg_beats = 16'd0;
        inp_valid = 4'b0;
        oup_ready = 1'b0;
        step();
        check("rst_cfg_ready", {31'b0, cfg_ready}, 32'd1);
        check("rst_oup_valid", {31'b0, oup_valid}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // ALL mode, three back-to-back beats on inputs 0 and 2
        set_cfg(4'b0101, STREAM_JOIN_ALL, 16'd3);
        inp_valid = 4'b0101;
        oup_ready = 1'b1;
        step();
        cfg_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            check("all_valid", {31'b0, oup_valid}, 32'd1);
            check("all_ready", {28'b0, inp_ready}, 32'h5);
            step();
        end
        check("all_done", {31'b0, done}, 32'd1);
        check("all_cnt", {16'b0, beat_cnt}, 32'd3);
        step();
        check("all_done_1cyc", {31'b0, done}, 32'd0);
        check("all_cnt_hold", {16'b0, beat_cnt}, 32'd3);

        // ALL mode waits for the late input
        set_cfg(4'b0011, STREAM_JOIN_ALL, 16'd1);
        inp_valid = 4'b0001;
        step();
        cfg_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("wait_valid", {31'b0, oup_valid}, 32'd0);
            check("wait_ready0", {31'b0, inp_ready[0]}, 32'd0);
            check("wait_cnt", {16'b0, beat_cnt}, 32'd0);
            step();
        end
        inp_valid = 4'b0011;
        #1;
        check("late_ready", {28'b0, inp_ready}, 32'h3);
        step();
        check("late_done", {31'b0, done}, 32'd1);
        check("late_cnt", {16'b0, beat_cnt}, 32'd1);

        // ANY mode, input 0 is not selected and must never be readied
        set_cfg(4'b1110, STREAM_JOIN_ANY, 16'd2);
        inp_valid = 4'b0000;
        step();
        cfg_valid = 1'b0;
        inp_valid = 4'b0101;
        #1;
        check("any_sel1", {28'b0, oup_sel}, 32'h4);
        check("any_rdy1", {28'b0, inp_ready}, 32'h4);
        step();
        inp_valid = 4'b1011;
        #1;
        check("any_sel2", {28'b0, oup_sel}, 32'hA);
        check("any_rdy2", {28'b0, inp_ready}, 32'hA);
        step();
        check("any_done", {31'b0, done}, 32'd1);
        check("any_cnt", {16'b0, beat_cnt}, 32'd2);
        inp_valid = 4'b0000;

        // Empty jobs: zero beats, then empty select; second accepted while done is high
        set_cfg(4'b1111, STREAM_JOIN_ALL, 16'd0);
        step();
        check("empty0_done", {31'b0, done}, 32'd1);
        check("empty0_busy", {31'b0, busy}, 32'd0);
        set_cfg(4'b0000, STREAM_JOIN_ANY, 16'd5);
        step();
        check("empty1_done", {31'b0, done}, 32'd1);
        check("empty1_cnt", {16'b0, beat_cnt}, 32'd0);
        cfg_valid = 1'b0;
        step();
        check("empty_done_clr", {31'b0, done}, 32'd0);

        // Back-to-back jobs with cfg_valid held high
        set_cfg(4'b0001, STREAM_JOIN_ALL, 16'd2);
        inp_valid = 4'b0001;
        oup_ready = 1'b1;
        step();
        check("b2b_cfg_rdy_a", {31'b0, cfg_ready}, 32'd0);
        step();
        check("b2b_cfg_rdy_b", {31'b0, cfg_ready}, 32'd0);
        step();
        check("b2b_done1", {31'b0, done}, 32'd1);
        check("b2b_cfg_rdy_c", {31'b0, cfg_ready}, 32'd1);
        step();
        cfg_valid = 1'b0;
        check("b2b_busy2", {31'b0, busy}, 32'd1);
        check("b2b_cnt_clr", {16'b0, beat_cnt}, 32'd0);
        step();
        step();
        check("b2b_done2", {31'b0, done}, 32'd1);
        check("b2b_cnt2", {16'b0, beat_cnt}, 32'd2);
        step();

        // Backpressure, then reset in the middle of a job
        set_cfg(4'b0001, STREAM_JOIN_ALL, 16'd4);
        oup_ready = 1'b0;
        step();
        cfg_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", {31'b0, oup_valid}, 32'd1);
            check("bp_cnt", {16'b0, beat_cnt}, 32'd0);
            step();
        end
        oup_ready = 1'b1;
        step();
        check("bp_cnt1", {16'b0, beat_cnt}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_cfg_rdy", {31'b0, cfg_ready}, 32'd1);
        check("rst_done", {31'b0, done}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_done", {31'b0, done}, 32'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_join_sched.md
Name: stream_join_sched

Overview:
- Job-based scheduler that sequences a runtime-configurable stream join over NumInp input streams.
- A job (input select mask, join mode ALL/ANY, beat count) is accepted over a config handshake, then the join runs for exactly that many output beats, then the block reports completion.
- Sits between a DMA/cluster controller issuing jobs and the datapath merging streams.
- No buffering on the data path: valid/ready pass with zero latency.

Parameters:
- NumInp, 4, number of input streams (>=1).
- CntWidth, 16, width of the beat counter and of cfg_beats_i.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cfg_valid_i  in  1  job request valid
- cfg_ready_o  out  1  job request ready; high only in IDLE
- cfg_sel_i  in  NumInp  inputs participating in the job
- cfg_mode_i  in  stream_join_mode_e  ALL or ANY
- cfg_beats_i  in  CntWidth  output beats in the job; 0 = empty job
- inp_valid_i  in  NumInp  input stream valids
- inp_ready_o  out  NumInp  input stream readies
- oup_valid_o  out  1  joined output valid
- oup_ready_i  in  1  joined output ready
- oup_sel_o  out  NumInp  inputs consumed by the current output beat
- busy_o  out  1  job in progress (state ACTIVE)
- done_o  out  1  one-cycle pulse on job completion
- beat_cnt_o  out  CntWidth  beats transferred in the current or last job

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE; sel_q=0, mode_q=ALL, remaining_q=0, beat_cnt_o=0, done_o=0.
  - All outputs are derived from these, so oup_valid_o=0, inp_ready_o=0, busy_o=0, cfg_ready_o=1.
- States: IDLE, ACTIVE.
- IDLE:
  - cfg_ready_o=1; inp_ready_o=0; oup_valid_o=0.
  - On cfg handshake: latch sel/mode/beats and clear beat_cnt_o.
    - If cfg_beats_i==0 or cfg_sel_i==0: stay IDLE; done_o=1 in the next cycle.
    - Otherwise: next state ACTIVE.
- ACTIVE, ALL mode:
  - oup_valid_o = &(inp_valid_i | ~sel_q).
  - inp_ready_o[i] = sel_q[i] & oup_valid_o & oup_ready_i.
  - oup_sel_o = sel_q.
- ACTIVE, ANY mode:
  - oup_valid_o = |(inp_valid_i & sel_q).
  - inp_ready_o[i] = sel_q[i] & inp_valid_i[i] & oup_ready_i.
  - oup_sel_o = inp_valid_i & sel_q.
- Unselected inputs: inp_ready_o=0 always.
- Beat transfer = oup_valid_o & oup_ready_i. Each transfer decrements remaining_q and increments beat_cnt_o.
- Last transfer (remaining_q==1):
  - Next cycle: state=IDLE and done_o=1 (registered, exactly one cycle).
  - cfg_ready_o rises in that same cycle, so a new job may be accepted in the cycle done_o is high. Minimum job-to-job gap: 1 cycle.
- cfg_ready_o=0 in ACTIVE. cfg_valid_i held high then is ignored, and is accepted once IDLE is re-entered.
- Zero latency, purely combinational valid/ready in ACTIVE. No combinational path from cfg_* to the data handshake: config is only used after being registered.
- Ready/valid protocol: output drops valid only after a handshake. In ANY mode, oup_sel_o may change while oup_valid_o=1 without ready, if an input raises valid. This is allowed and documented for consumers.
- beat_cnt_o:
  - Holds its value after done until the next cfg handshake.
  - Saturation is not needed, because count <= cfg_beats_i.
- Reset mid-job: immediate return to IDLE. No done_o pulse. In-flight beats are lost (upstream responsibility).

Decomposition:
- stream_join_pkg: keeps stream_join_mode_e. Add stream_join_sched_state_e {IDLE, ACTIVE} so the bench can probe the state.
- Sub-module stream_join_dynamic (combinational): inputs sel, mode, valids, oup_ready; outputs valid/readies/oup_sel. Reusable wherever a runtime mode join is needed.
- stream_join_sched keeps only the FSM, config registers and counters.

Test Plan:
- ALL mode, sel=4'b0101, beats=3, inputs 0 and 2 always valid, oup_ready=1 -> 3 beats in consecutive cycles, inp_ready_o=4'b0101 on each, done_o one cycle after 3rd beat, beat_cnt_o=3.
- ALL mode, sel=4'b0011, input 1 valid delayed 4 cycles -> oup_valid_o=0 and inp_ready_o[0]=0 until input 1 valid; no beat counted early.
- ANY mode, sel=4'b1110, beats=2, only input 2 valid then inputs 1 and 3 valid -> beat1 oup_sel_o=4'b0100, beat2 oup_sel_o=4'b1010; input 0 valid ignored (ready 0).
- Empty jobs: beats=0 with sel=4'b1111, then sel=0 with beats=5 -> each accepted in IDLE, done_o pulses next cycle, oup_valid_o never 1, beat_cnt_o=0.
- Back-to-back: cfg_valid_i held high with jobs of 2 beats -> second cfg accepted in the cycle done_o=1; cfg_ready_o=0 throughout ACTIVE.
- Backpressure plus reset: oup_ready_i=0 for 5 cycles in ACTIVE -> valid held, counter frozen. Then rst_ni=0 mid-job -> state IDLE, busy_o=0, no done_o, cfg_ready_o=1 immediately.
